// File: rtl/fpu_req_issuer.sv
// fpu_req_issuer: valid/ready front end for the pipelined fpu core with an in-order, credit-protected response FIFO.
// Define FPU_OP_CHECK_EN to trap opcodes 6/7 as qNaN error responses instead of passing them to the core.
module fpu_req_issuer #(
    parameter int LATENCY   = 4,
    parameter int RES_DEPTH = 8,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [1:0]       req_rmode,
    input  logic [31:0]      req_opa,
    input  logic [31:0]      req_opb,
    input  logic [TAG_W-1:0] req_tag,
    output logic [2:0]       fpu_op,
    output logic [1:0]       rmode,
    output logic [31:0]      opa,
    output logic [31:0]      opb,
    input  logic [31:0]      fpu_out,
    input  logic [7:0]       fpu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_out,
    output logic [7:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             busy
);
    localparam int CW = $clog2(RES_DEPTH) + 1;
    localparam int PW = $clog2(RES_DEPTH);
    localparam int EW = 41 + TAG_W;

    logic issue, cap, pop, op_err;
    logic [LATENCY:0] stg_v, stg_e;
    logic [LATENCY:0][TAG_W-1:0] stg_tag;
    logic [CW-1:0] inflight, fifo_cnt, inflight_nx, fifo_cnt_nx, cnt_left;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [EW-1:0] mem [RES_DEPTH];
    logic [EW-1:0] cap_ent, front;
    logic [31:0] cap_res;
    logic [7:0] cap_flg;

    assign issue = req_valid && req_ready;
    assign cap = stg_v[LATENCY];
    assign pop = rsp_valid && rsp_ready;
    assign rsp_valid = fifo_cnt != 0;
    assign busy = (inflight != 0) || (fifo_cnt != 0);

`ifdef FPU_OP_CHECK_EN
    assign op_err = req_op[2] & req_op[1];
    assign cap_res = stg_e[LATENCY] ? 32'h7FC0_0000 : fpu_out;
    assign cap_flg = stg_e[LATENCY] ? 8'h04 : fpu_flags;
`else
    assign op_err = 1'b0;
    assign cap_res = fpu_out;
    assign cap_flg = fpu_flags;
`endif

    // The output registers show the FIFO head; when the FIFO drains to empty the captured entry bypasses memory.
    always_comb begin
        inflight_nx = inflight + CW'(issue) - CW'(cap);
        fifo_cnt_nx = fifo_cnt + CW'(cap) - CW'(pop);
        cnt_left = fifo_cnt - CW'(pop);
        cap_ent = {cap_res, cap_flg, stg_tag[LATENCY], stg_e[LATENCY]};
        front = (cnt_left != 0) ? mem[rd_ptr + PW'(pop)] : cap_ent;
    end

    always_ff @(posedge clk) begin
        if (cap) mem[wr_ptr] <= cap_ent;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_v <= '0;
            stg_e <= '0;
            stg_tag <= '0;
            inflight <= '0;
            fifo_cnt <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            req_ready <= 1'b0;
            fpu_op <= '0;
            rmode <= '0;
            opa <= '0;
            opb <= '0;
            {rsp_out, rsp_flags, rsp_tag, rsp_err} <= '0;
        end else begin
            stg_v <= {stg_v[LATENCY-1:0], issue};
            stg_e <= {stg_e[LATENCY-1:0], issue & op_err};
            stg_tag <= {stg_tag[LATENCY-1:0], req_tag};
            inflight <= inflight_nx;
            fifo_cnt <= fifo_cnt_nx;
            // Credits: every in-flight op already owns a FIFO slot, so a capture can never overflow.
            req_ready <= (inflight_nx + fifo_cnt_nx) < CW'(RES_DEPTH);
            if (cap) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (issue) begin
                fpu_op <= op_err ? 3'd0 : req_op;
                rmode <= req_rmode;
                opa <= req_opa;
                opb <= req_opb;
            end
            if (cnt_left != 0 || cap) {rsp_out, rsp_flags, rsp_tag, rsp_err} <= front;
        end
    end
endmodule
